// File: rtl/conv_pkg.sv
// Shared constants and types for the K=3, rate-1/2 (7,5 octal) convolutional encoder.
package conv_pkg;

    localparam int K = 3;
    localparam logic [K-1:0] G0 = 3'b111;
    localparam logic [K-1:0] G1 = 3'b101;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ENC_HI   = 3'd1,
        OUT_HI   = 3'd2,
        ENC_LO   = 3'd3,
        OUT_LO   = 3'd4,
        TAIL     = 3'd5,
        OUT_TAIL = 3'd6
    } enc_state_t;

    // Parity of the register window {u, s1, s0} under one generator tap mask.
    function automatic logic gen_parity(input logic [K-1:0] window, input logic [K-1:0] taps);
        return ^(window & taps);
    endfunction

endpackage

// File: rtl/conv_k3_core.sv
// Single-bit K=3 encoder: combinational code pair from {u, s1, s0} plus the two-bit history register.
module conv_k3_core
    import conv_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic u,
    input  logic en,
    input  logic clr,
    output logic c0,
    output logic c1
);

    logic [K-2:0] sh_r;  // {s1, s0}
    logic [K-1:0] window_s;

    // Code pair for the bit presented this cycle.
    always_comb begin
        window_s = {u, sh_r};
        c0       = gen_parity(window_s, G0);
        c1       = gen_parity(window_s, G1);
    end

    // History register: s1 <= u, s0 <= s1; clr overrides en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_r <= {(K-1){1'b0}};
        end else if (clr) begin
            sh_r <= {(K-1){1'b0}};
        end else if (en) begin
            sh_r <= {u, sh_r[K-2]};
        end else begin
            sh_r <= sh_r;
        end
    end

endmodule

// File: rtl/conv_encode_stream.sv
// Streaming rate-1/2 K=3 encoder: one payload byte in, two packed code bytes out, optional zero-tail byte per frame.
module conv_encode_stream
    import conv_pkg::*;
#(
    parameter int FRAME_BYTES = 4,
    parameter bit TAIL_EN     = 1'b1
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       busy,
    output logic       frame_done
);

    localparam int            CW       = $clog2(FRAME_BYTES + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_BYTES);

    enc_state_t    state_r, state_s;
    logic [7:0]    byte_r;
    logic [5:0]    sr_r;
    logic [7:0]    out_data_r;
    logic [7:0]    out_byte_s;
    logic [2:0]    bit_idx_r;
    logic [CW-1:0] cnt_r, cnt_s, cnt_inc_s;
    logic          in_ready_r, out_valid_r, busy_r, frame_done_r;
    logic          accept_s, enc_en_s, last_enc_s, tail_start_s, frame_end_s;
    logic          u_s, c0_s, c1_s, core_clr_s;

    assign core_clr_s = clear | frame_end_s;

    conv_k3_core u_core (
        .clk (clk),
        .rst (rst),
        .u   (u_s),
        .en  (enc_en_s),
        .clr (core_clr_s),
        .c0  (c0_s),
        .c1  (c1_s)
    );

    // Next-state and per-cycle control; clear pre-empts every handshake.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        cnt_inc_s    = cnt_r + CW'(1'b1);
        accept_s     = 1'b0;
        enc_en_s     = 1'b0;
        last_enc_s   = 1'b0;
        tail_start_s = 1'b0;
        frame_end_s  = 1'b0;
        u_s          = 1'b0;
        out_byte_s   = {sr_r, c0_s, c1_s};
        if (clear) begin
            state_s = IDLE;
            cnt_s   = {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        accept_s = 1'b1;
                        state_s  = ENC_HI;
                    end else begin
                        state_s = IDLE;
                    end
                end
                ENC_HI: begin
                    enc_en_s = 1'b1;
                    u_s      = byte_r[bit_idx_r];
                    if (bit_idx_r == 3'd4) begin
                        last_enc_s = 1'b1;
                        state_s    = OUT_HI;
                    end else begin
                        state_s = ENC_HI;
                    end
                end
                OUT_HI: begin
                    if (out_ready) begin
                        state_s = ENC_LO;
                    end else begin
                        state_s = OUT_HI;
                    end
                end
                ENC_LO: begin
                    enc_en_s = 1'b1;
                    u_s      = byte_r[bit_idx_r];
                    if (bit_idx_r == 3'd0) begin
                        last_enc_s = 1'b1;
                        state_s    = OUT_LO;
                    end else begin
                        state_s = ENC_LO;
                    end
                end
                OUT_LO: begin
                    if (out_ready) begin
                        if (cnt_inc_s == LAST_CNT) begin
                            if (TAIL_EN) begin
                                state_s      = TAIL;
                                cnt_s        = cnt_inc_s;
                                tail_start_s = 1'b1;
                            end else begin
                                state_s     = IDLE;
                                cnt_s       = {CW{1'b0}};
                                frame_end_s = 1'b1;
                            end
                        end else begin
                            state_s = IDLE;
                            cnt_s   = cnt_inc_s;
                        end
                    end else begin
                        state_s = OUT_LO;
                    end
                end
                TAIL: begin
                    enc_en_s = 1'b1;
                    if (bit_idx_r == 3'd0) begin
                        last_enc_s = 1'b1;
                        state_s    = OUT_TAIL;
                    end else begin
                        state_s = TAIL;
                    end
                end
                OUT_TAIL: begin
                    if (out_ready) begin
                        state_s     = IDLE;
                        cnt_s       = {CW{1'b0}};
                        frame_end_s = 1'b1;
                    end else begin
                        state_s = OUT_TAIL;
                    end
                end
                default: begin
                    state_s = IDLE;
                    cnt_s   = {CW{1'b0}};
                end
            endcase
        end
    end

    // State, counter and registered handshake/status outputs derived from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            cnt_r        <= {CW{1'b0}};
            in_ready_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            in_ready_r   <= (state_s == IDLE);
            out_valid_r  <= (state_s == OUT_HI) || (state_s == OUT_LO) || (state_s == OUT_TAIL);
            busy_r       <= (cnt_s != {CW{1'b0}}) || (state_s != IDLE);
            frame_done_r <= frame_end_s;
        end
    end

    // Payload latch, bit pointer and pair accumulator; out_data only changes when a new byte completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_r     <= 8'h00;
            bit_idx_r  <= 3'd0;
            sr_r       <= 6'd0;
            out_data_r <= 8'h00;
        end else if (clear) begin
            sr_r       <= 6'd0;
            out_data_r <= 8'h00;
        end else begin
            if (accept_s) begin
                byte_r    <= in_data;
                bit_idx_r <= 3'd7;
            end else if (tail_start_s) begin
                bit_idx_r <= 3'd1;
            end else if (enc_en_s) begin
                bit_idx_r <= bit_idx_r - 3'd1;
            end
            if (enc_en_s) begin
                sr_r <= out_byte_s[5:0];
            end
            if (last_enc_s) begin
                out_data_r <= (state_r == TAIL) ? {out_byte_s[3:0], 4'h0} : out_byte_s;
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule

// File: doc/conv_encode_stream.md
Name: conv_encode_stream

Overview:
Streaming rate-1/2, K=3 convolutional encoder (generators 7,5 octal). It sits between the UART receive byte stream and the UART transmit sequencer.
- Accepts payload bytes on a valid/ready input.
- Encodes each bit MSB-first.
- Packs every 8 encoded bits into an output byte on a valid/ready output.
- At the end of each frame, appends a zero-tail flush byte when TAIL_EN=1.

Parameters:
FRAME_BYTES, 4, payload bytes per frame (must be ≥1)
TAIL_EN, 1, 1 = append K-1=2 zero tail bits after the last payload byte, encoded and padded to one output byte

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
clear  input  1  synchronous abort: returns to IDLE, zeroes encoder state and byte count
in_valid  input  1  in_data valid
in_data  input  8  payload byte
in_ready  output  1  block accepts in_data this cycle
out_valid  output  1  out_data valid
out_data  output  8  encoded byte
out_ready  input  1  downstream accepts out_data
busy  output  1  frame in progress (byte_cnt≠0 or state≠IDLE)
frame_done  output  1  one-cycle pulse after the last byte of a frame is accepted downstream

Behaviour:
- Reset (rst=0, async):
  - State = IDLE.
  - Shift state s1 = s0 = 0, byte_cnt = 0.
  - in_ready = 0 during reset, then 1 in IDLE after release.
  - out_valid, out_data, busy and frame_done are all 0.
  - Reset mid-operation discards all partial data; no output is produced for it.
- Encoder equations, per input bit u:
  - c0 = u^s1^s0, c1 = u^s0.
  - Then s0 <= s1, s1 <= u.
  - The pair is emitted c0 then c1; pairs fill the output byte MSB-first.
  - Each input byte produces exactly two output bytes: bits 7..4 form the first, bits 3..0 the second.
- States:
  - IDLE: in_ready=1. On in_valid: latch in_data, set bit index = 7, go to ENC_HI.
  - ENC_HI: one input bit per cycle for 4 cycles, filling the 8-bit output shift register. Then go to OUT_HI.
  - OUT_HI: out_valid=1 with data held stable. On out_ready, go to ENC_LO.
  - ENC_LO: 4 cycles, same as ENC_HI. Then go to OUT_LO.
  - OUT_LO: on out_ready, byte_cnt++.
    - If byte_cnt reaches FRAME_BYTES and TAIL_EN=1: go to TAIL.
    - If byte_cnt reaches FRAME_BYTES and TAIL_EN=0: pulse frame_done, zero s1/s0/byte_cnt, go to IDLE.
    - Otherwise: go to IDLE.
  - TAIL: 2 cycles encoding u=0; the resulting 4 bits go in out_data[7:4], and out_data[3:0]=0. Then go to OUT_TAIL.
  - OUT_TAIL: on out_ready, pulse frame_done, zero s1/s0/byte_cnt, go to IDLE.
- Latency:
  - Byte accepted at edge T; first output byte has out_valid=1 from cycle T+5.
  - With out_ready tied high, the second byte is valid 5 cycles after the first handshake.
- Handshake rules:
  - out_data and out_valid stay constant until the handshake completes.
  - in_ready is high only in IDLE; there is no input buffering.
  - out_valid does not depend combinationally on out_ready.
- Encoder state persists across bytes within a frame. It zeroes only at frame end, on clear, or on reset.
- clear has priority over all handshakes in the same cycle:
  - A coincident in_valid is not accepted.
  - A coincident out_ready does not count as a transfer, and frame_done does not pulse.
- byte_cnt width is $clog2(FRAME_BYTES+1) and it never wraps past FRAME_BYTES.

Decomposition:
- Package conv_pkg holds:
  - K=3 and the generator constants G0=3'b111, G1=3'b101.
  - State enum enc_state_t {IDLE, ENC_HI, OUT_HI, ENC_LO, OUT_LO, TAIL, OUT_TAIL}.
- Sub-module conv_k3_core: combinational-plus-register single-bit encoder (u, en, clr → c0, c1, state). It is reused by the tail path and shareable with encoder_k3 refactoring.

Test Plan:
- FRAME_BYTES=1, TAIL_EN=1, out_ready=1; send 0x80 → outputs 0xEC, 0x00, tail 0x00; frame_done one cycle after the tail handshake.
- FRAME_BYTES=1, TAIL_EN=1; send 0xFF → 0xDA, 0xAA, tail 0x70 (state s1=s0=1 before flush).
- FRAME_BYTES=4, TAIL_EN=1; send 0x80,0x00,0x00,0x00 → 0xEC followed by seven 0x00 bytes, then tail 0x00 (9 bytes); busy high from the first accept until after frame_done; a following frame 0x80 again yields 0xEC (state zeroed).
- Backpressure: hold out_ready=0 for 5 cycles in OUT_HI → out_valid stays 1 and out_data stays stable; in_ready stays 0; the sequence resumes correctly.
- clear asserted in ENC_LO of byte 2 with in_valid and out_ready high → IDLE next cycle, no frame_done, no byte accepted; then 0xFF → 0xDA, 0xAA.
- Async rst pulse mid-OUT_HI → out_valid=0 immediately; after release, 0x80 → 0xEC, 0x00.
